// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: NOP encoding, base opcodes and the fetch-stage
// state encoding used by fetch_unit.
package rv32_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and
// instruction memory (slave).
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] im_addr;
    logic             im_req;
    logic             im_ack;
    logic [WIDTH-1:0] im_rdata;

    modport master (
        output im_addr,
        output im_req,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_addr,
        input  im_req,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC mux, registered pc+4 and optional
// misaligned-target check (enabled by defining FETCH_MISALIGN_CHECK_EN).
module fetch_pc_reg
    import rv32_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic             sel,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misaligned
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] plus4_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] target_aligned;
    logic             pc_load;

    assign target_aligned = branch_target & ALIGN_MASK;
    assign pc_next        = sel ? target_aligned : plus4_reg;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_reg;
    logic bad_target;

    // A misaligned jump target freezes the PC and raises a sticky flag.
    assign bad_target = commit && sel && (branch_target[1:0] != 2'b00);
    assign pc_load    = commit && !bad_target;
    assign misaligned = misaligned_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_reg <= 1'b0;
        end else if (bad_target) begin
            misaligned_reg <= 1'b1;
        end
    end
`else
    assign pc_load    = commit;
    assign misaligned = 1'b0;
`endif

    // pc+4 is kept registered alongside pc so the link value is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            plus4_reg <= RESET_PC + FOUR;
        end else if (pc_load) begin
            pc_reg    <= pc_next;
            plus4_reg <= pc_next + FOUR;
        end
    end

    assign pc       = pc_reg;
    assign pc_plus4 = plus4_reg;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC, im req/ack handshake, instruction latch
// and field decode. Optional feature macro: FETCH_MISALIGN_CHECK_EN.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_req,
    input  logic                pc_update,
    input  logic                PC_stall,
    input  logic                PC_MUX_sel,
    input  logic [WIDTH-1:0]    branch_target,
    fetch_unit_if.master        im,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_plus4,
    output logic [WIDTH-1:0]    instr,
    output logic [6:0]          opcode,
    output logic [2:0]          func3,
    output logic [6:0]          func7,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic                instr_valid,
    output logic                fetch_busy,
    output logic                misaligned
);

    fetch_state_t     state_reg;
    logic             im_req_reg;
    logic             instr_valid_reg;
    logic             fetch_busy_reg;
    logic [WIDTH-1:0] instr_reg;
    logic [WIDTH-1:0] pc_cur;
    logic             pc_commit;

    // The PC must not move while memory is being addressed with it.
    assign pc_commit = pc_update && !PC_stall && (state_reg != ST_FETCH);

    fetch_pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .commit        (pc_commit),
        .sel           (PC_MUX_sel),
        .branch_target (branch_target),
        .pc            (pc_cur),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            im_req_reg      <= 1'b0;
            instr_valid_reg <= 1'b0;
            fetch_busy_reg  <= 1'b0;
            instr_reg       <= WIDTH'(NOP);
        end else begin
            case (state_reg)
                ST_IDLE, ST_VALID: begin
                    if (fetch_req) begin
                        state_reg       <= ST_FETCH;
                        im_req_reg      <= 1'b1;
                        fetch_busy_reg  <= 1'b1;
                        instr_valid_reg <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // Further fetch_req pulses are dropped until the ack arrives.
                    if (im.im_ack) begin
                        state_reg       <= ST_VALID;
                        im_req_reg      <= 1'b0;
                        fetch_busy_reg  <= 1'b0;
                        instr_valid_reg <= 1'b1;
                        instr_reg       <= im.im_rdata;
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    im_req_reg      <= 1'b0;
                    fetch_busy_reg  <= 1'b0;
                    instr_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign im.im_req   = im_req_reg;
    assign im.im_addr  = pc_cur;
    assign pc          = pc_cur;
    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign fetch_busy  = fetch_busy_reg;

    assign opcode = instr_reg[6:0];
    assign rd     = instr_reg[11:7];
    assign func3  = instr_reg[14:12];
    assign rs1    = instr_reg[19:15];
    assign rs2    = instr_reg[24:20];
    assign func7  = instr_reg[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a transaction-level
// model of PC, latched instruction and sticky misaligned flag.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        pc_update;
    logic        PC_stall;
    logic        PC_MUX_sel;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        instr_valid;
    logic        fetch_busy;
    logic        misaligned;

    fetch_unit_if #(.WIDTH(32)) im_bus ();

    fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .pc_update     (pc_update),
        .PC_stall      (PC_stall),
        .PC_MUX_sel    (PC_MUX_sel),
        .branch_target (branch_target),
        .im            (im_bus),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instr         (instr),
        .opcode        (opcode),
        .func3         (func3),
        .func7         (func7),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .instr_valid   (instr_valid),
        .fetch_busy    (fetch_busy),
        .misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, " pc"},       pc,                 m_pc);
        check({tag, " pc_plus4"}, pc_plus4,           m_pc + 32'd4);
        check({tag, " im_addr"},  im_bus.im_addr,     m_pc);
        check({tag, " instr"},    instr,              m_instr);
        check({tag, " valid"},    32'(instr_valid),   32'(m_valid));
        check({tag, " mis"},      32'(misaligned),    32'(m_mis));
        check({tag, " opcode"},   32'(opcode),        m_instr & 32'h7F);
        check({tag, " rd"},       32'(rd),            (m_instr >> 7) & 32'h1F);
        check({tag, " func3"},    32'(func3),         (m_instr >> 12) & 32'h7);
        check({tag, " rs1"},      32'(rs1),           (m_instr >> 15) & 32'h1F);
        check({tag, " rs2"},      32'(rs2),           (m_instr >> 20) & 32'h1F);
        check({tag, " func7"},    32'(func7),         m_instr >> 25);
    endtask

    // Next PC as the control unit's commit rule describes it.
    task automatic model_commit(input logic sel, input logic [31:0] target);
`ifdef FETCH_MISALIGN_CHECK_EN
        if (sel && (target % 4 != 0)) begin
            m_mis = 1'b1;
            return;
        end
`endif
        if (sel) m_pc = target - (target % 4);
        else     m_pc = m_pc + 32'd4;
    endtask

    task automatic pc_upd(input logic sel, input logic [31:0] target, input logic stall);
        pc_update     = 1'b1;
        PC_MUX_sel    = sel;
        branch_target = target;
        PC_stall      = stall;
        step();
        pc_update = 1'b0;
        PC_stall  = 1'b0;
        if (!stall) model_commit(sel, target);
        $display("pc_update sel=%0d target=0x%08h stall=%0d -> pc=0x%08h", sel, target, stall, pc);
        check("upd pc",       pc,               m_pc);
        check("upd pc_plus4", pc_plus4,         m_pc + 32'd4);
        check("upd mis",      32'(misaligned),  32'(m_mis));
    endtask

    task automatic do_fetch(input int k, input logic [31:0] data, input bit noise);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        m_valid   = 1'b0;
        check("fetch im_req",  32'(im_bus.im_req), 32'd1);
        check("fetch busy",    32'(fetch_busy),    32'd1);
        check("fetch valid",   32'(instr_valid),   32'd0);
        check("fetch im_addr", im_bus.im_addr,     m_pc);
        for (int i = 1; i < k; i++) begin
            fetch_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            check("wait im_req",  32'(im_bus.im_req), 32'd1);
            check("wait im_addr", im_bus.im_addr,     m_pc);
        end
        fetch_req       = 1'b0;
        im_bus.im_ack   = 1'b1;
        im_bus.im_rdata = data;
        step();
        im_bus.im_ack   = 1'b0;
        im_bus.im_rdata = $urandom;
        m_instr = data;
        m_valid = 1'b1;
        $display("fetch addr=0x%08h delay=%0d data=0x%08h -> instr=0x%08h valid=%0d", m_pc, k, data, instr, instr_valid);
        check("done im_req", 32'(im_bus.im_req), 32'd0);
        check("done busy",   32'(fetch_busy),    32'd0);
        check_state("done");
    endtask

    initial begin
        rst             = 1'b1;
        fetch_req       = 1'b0;
        pc_update       = 1'b0;
        PC_stall        = 1'b0;
        PC_MUX_sel      = 1'b0;
        branch_target   = '0;
        im_bus.im_ack   = 1'b0;
        im_bus.im_rdata = '0;
        m_pc = RESET_PC; m_instr = NOP_W; m_valid = 1'b0; m_mis = 1'b0;

        #2;
        check("rst im_req", 32'(im_bus.im_req), 32'd0);
        check("rst busy",   32'(fetch_busy),    32'd0);
        check_state("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed: R-type add x5,x5,x6 with ack in first FETCH cycle
        do_fetch(1, 32'h0062_82B3, 1'b0);
        check("add opcode", 32'(opcode), 32'h33);
        check("add rd",     32'(rd),     32'd5);
        check("add rs1",    32'(rs1),    32'd5);
        check("add rs2",    32'(rs2),    32'd6);

        // Delayed ack with spurious fetch_req pulses
        do_fetch(5, 32'hDEAD_BEEF, 1'b1);

        pc_upd(1'b1, 32'h0000_0100, 1'b0);
        pc_upd(1'b0, 32'h0000_0000, 1'b0);
        check("pc 0x104", pc, 32'h0000_0104);
        pc_upd(1'b1, 32'h0000_0200, 1'b0);
        pc_upd(1'b1, 32'h0000_0300, 1'b1);
        check("stall pc", pc, 32'h0000_0200);
        pc_upd(1'b1, 32'hFFFF_FFFC, 1'b0);
        pc_upd(1'b0, 32'h0000_0000, 1'b0);
        check("wrap pc",    pc,       32'h0000_0000);
        check("wrap plus4", pc_plus4, 32'h0000_0004);
        pc_upd(1'b1, 32'h0000_0200, 1'b0);
        pc_upd(1'b1, 32'h0000_0202, 1'b0);

        // pc_update during FETCH is ignored
        fetch_req = 1'b1;
        step();
        fetch_req  = 1'b0;
        m_valid    = 1'b0;
        pc_update  = 1'b1; PC_MUX_sel = 1'b1; branch_target = 32'h0000_0400;
        step();
        pc_update  = 1'b0;
        check("fetch-upd pc", pc, m_pc);
        im_bus.im_ack = 1'b1; im_bus.im_rdata = 32'h0000_0513;
        step();
        im_bus.im_ack = 1'b0;
        m_instr = 32'h0000_0513; m_valid = 1'b1;
        check_state("fetch-upd");

        // pc_update together with fetch_req: fetch uses the new PC
        fetch_req = 1'b1; pc_update = 1'b1; PC_MUX_sel = 1'b0;
        step();
        fetch_req = 1'b0; pc_update = 1'b0;
        model_commit(1'b0, 32'h0);
        m_valid = 1'b0;
        check("same im_req",  32'(im_bus.im_req), 32'd1);
        check("same im_addr", im_bus.im_addr,     m_pc);
        im_bus.im_ack = 1'b1; im_bus.im_rdata = 32'h0040_006F;
        step();
        im_bus.im_ack = 1'b0;
        m_instr = 32'h0040_006F; m_valid = 1'b1;
        check_state("same");

        // Randomized mix of commits and fetches
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                logic [31:0] tgt;
                tgt = $urandom;
                if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
                pc_upd(1'($urandom_range(0, 1)), tgt, ($urandom_range(0, 4) == 0));
            end else begin
                do_fetch(int'($urandom_range(1, 6)), $urandom, 1'b1);
            end
        end

        // Reset in the middle of a fetch
        pc_upd(1'b1, 32'h0000_0ABC, 1'b0);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("pre-rst im_req", 32'(im_bus.im_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        m_pc = RESET_PC; m_instr = NOP_W; m_valid = 1'b0; m_mis = 1'b0;
        $display("reset mid-fetch -> im_req=%0d pc=0x%08h instr=0x%08h", im_bus.im_req, pc, instr);
        check("midrst im_req", 32'(im_bus.im_req), 32'd0);
        check("midrst busy",   32'(fetch_busy),    32'd0);
        check_state("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        im_bus.im_ack = 1'b1; im_bus.im_rdata = 32'h1234_5678;
        step();
        im_bus.im_ack = 1'b0;
        check("late-ack im_req", 32'(im_bus.im_req), 32'd0);
        check_state("late-ack");
        do_fetch(2, 32'h00A0_0093, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32I multi-cycle core, directly upstream of the control unit. Holds the program counter and requests one instruction word per fetch from instruction memory over a req/ack handshake. Latches the returned word and presents decoded fields (opcode, func3, func7, register indices) to the control unit. Applies the control unit's PC_MUX_sel/PC_stall decision to advance the PC.

## Interface
- WIDTH, 32, datapath/address width
- RESET_PC, 32'h0000_0000, PC value on reset

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  one-cycle pulse from control unit to start a fetch
- pc_update  in  1  one-cycle pulse: commit next PC (end of instruction)
- PC_stall  in  1  when high, pc_update is ignored
- PC_MUX_sel  in  1  0: next PC = pc+4; 1: next PC = branch_target
- branch_target  in  WIDTH  jump/branch target from ALU
- im_addr  out  WIDTH  instruction memory address
- im_req  out  1  instruction memory request
- im_ack  in  1  memory returns im_rdata this cycle
- im_rdata  in  WIDTH  instruction word
- pc  out  WIDTH  PC of the latched instruction
- pc_plus4  out  WIDTH  pc+4 (link value for JAL/JALR)
- instr  out  WIDTH  latched instruction
- opcode  out  7  instr[6:0]; func3 out 3 instr[14:12]; func7 out 7 instr[31:25]
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20]
- instr_valid  out  1  latched instruction is current
- fetch_busy  out  1  fetch in progress
- misaligned  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- States: IDLE, FETCH, VALID. Reset -> IDLE.
- IDLE/VALID + fetch_req -> FETCH; instr_valid drops to 0 on entry.
- FETCH: im_req=1, im_addr=pc, fetch_busy=1. On im_ack: instr <= im_rdata, -> VALID.
- VALID: instr_valid=1, fields stable until next fetch_req.
- fetch_req in FETCH: ignored (no queueing).
- pc_update: if !PC_stall and state != FETCH, pc <= PC_MUX_sel ? branch_target : pc+4. In FETCH, ignored.
- pc_update and fetch_req same cycle: PC commits this edge; fetch starts next cycle using new PC.
- pc+4 wraps modulo 2^WIDTH (32'hFFFF_FFFC -> 0).
- Decoded fields are pure slices of instr register.
- Reset values: pc=RESET_PC, instr=32'h0000_0013 (NOP), im_req=0, instr_valid=0, fetch_busy=0, misaligned=0; im_addr=RESET_PC, pc_plus4=RESET_PC+4.

## Timing
- fetch_req at edge n -> im_req high from n+1; im_ack at n+k (k>=1) -> instr_valid high at n+k+1.
- Minimum fetch latency 2 cycles (ack in first FETCH cycle).
- im_req held high and im_addr constant until im_ack; no ack timeout.
- pc_update takes effect at the next edge; pc/pc_plus4 registered.
- rst asserted mid-fetch: im_req drops immediately (async); any late im_ack ignored.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: on pc_update with PC_MUX_sel=1 and branch_target[1:0]!=0, PC unchanged, misaligned set; cleared only by rst.
- Undefined: branch_target[1:0] forced to 00 on commit; misaligned tied to 0.

## Structure
- Shared package rv32_pkg: NOP constant 32'h0000_0013, RV32I opcode constants, fetch state encoding.
- One sub-module: fetch_pc_reg (PC register, next-PC mux, pc+4 adder, misalign check).

## Test plan
- Reset, fetch_req, im_ack next cycle with im_rdata=32'h0062_82B3 -> instr_valid 2 cycles after req; opcode=7'h33, rd=5, rs1=5, rs2=6, func3=0, func7=0.
- Ack delayed 5 cycles -> im_req and im_addr held stable all 5 cycles; extra fetch_req during wait ignored.
- pc_update PC_MUX_sel=0 from pc=0x100 -> pc=0x104; PC_MUX_sel=1, target 0x200 -> pc=0x200; PC_stall=1 -> pc unchanged.
- pc=32'hFFFF_FFFC, pc_update sel=0 -> pc=0, pc_plus4=4.
- Macro on: target 0x202 -> pc unchanged, misaligned=1; macro off: pc=0x200, misaligned=0.
- rst asserted mid-FETCH -> im_req=0 same cycle, pc=RESET_PC, instr=NOP, state IDLE; im_ack after release ignored.
